lsu_access_sequencer: RTL
=========================

Name: lsu_access_sequencer

Overview:
- Sits between the execute stage and the data-memory port and sequences every RV64 load/store.
- Accepts one request at a time and drives the aligned 64-bit memory port with byte strobes.
- Splits accesses that cross an 8-byte boundary into two aligned beats, then merges the read beats.
- Returns sign- or zero-extended load data, or a store completion, in a single-cycle response pulse.

Parameters:
- N, 64, data width in bits; fixed at 64 for this design.
- ADDR_W, 64, address width in bits.
- CNT_W, 16, width of the split-access statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  N  store data, right-justified.
- mem_req_valid  out  1  memory beat request.
- mem_req_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  8-byte-aligned beat address.
- mem_we  out  1  beat is a write.
- mem_wstrb  out  N/8  byte-write strobes; all zero on reads.
- mem_wdata  out  N  write data placed in byte lanes.
- mem_rvalid  in  1  one-cycle beat completion; carries read data or a write ack.
- mem_rdata  in  N  read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  N  extended load data; 0 for stores.
- resp_err  out  1  illegal funct3.
- split_count  out  CNT_W  number of split accesses accepted; wraps.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; mem_req_valid=0; mem_we=0; mem_wstrb=0; mem_addr=0; mem_wdata=0; resp_valid=0; resp_data=0; resp_err=0; split_count=0.
- Reset mid-operation aborts the access. Any later mem_rvalid for the aborted beat is ignored because the FSM is in IDLE.
- Accept: req_ready=1 only in IDLE. On req_valid&&req_ready, register we, funct3, addr, wdata.
- Size decode:
  - size = 1<<funct3[1:0]; off = addr[2:0].
  - Legal loads: funct3 000–110. Legal stores: funct3 000–011.
  - split = (off+size > 8).
- Beat 0: addr with [2:0] cleared; strobe = (size-byte mask << off)[7:0]; wdata shifted left by off*8, low 64 bits.
- Beat 1: beat-0 address + 8, wrapping modulo 2^ADDR_W; strobe = upper 8 bits of the 16-bit shifted mask; wdata = upper 64 bits of the 128-bit shifted data.
- Read-data merge: {beat1, beat0} >> off*8, low 64 bits. Then extend per funct3:
  - LB/LH/LW sign-extend; LD unmodified.
  - LBU/LHU/LWU zero-extend.
- FSM:
  - IDLE -> ERR on an illegal accept; no memory beat is issued.
  - IDLE -> REQ0 on a legal accept.
  - REQ0: mem_req_valid=1. Address, we, strobe and data stay stable until mem_req_ready. Handshake -> WAIT0.
  - WAIT0: mem_req_valid=0. On mem_rvalid, capture mem_rdata as beat0, then -> REQ1 if split, else RESP.
  - REQ1/WAIT1: same rules as REQ0/WAIT0 using beat-1 fields. On mem_rvalid -> RESP.
  - RESP: resp_valid=1 for exactly one cycle with registered resp_data; -> IDLE.
  - ERR: resp_valid=1 and resp_err=1 for one cycle; resp_data=0; -> IDLE.
- mem_rvalid is honoured only in WAIT0/WAIT1; it is ignored elsewhere, including when it arrives in the same cycle as the request handshake.
- split_count increments on each accepted legal split request, wrapping at 2^CNT_W.
- Latency from accept cycle T, with mem_req_ready=1 and mem_rvalid one cycle after each handshake:
  - Aligned access: mem_req_valid at T+1, rvalid at T+2, resp_valid at T+3.
  - Split access: resp_valid at T+5.
  - Illegal funct3: resp_valid at T+1.
- Back-to-back: req_ready returns in the cycle after RESP/ERR. No request is accepted in the same cycle as resp_valid.

Test Plan:
- Aligned LD, addr=0x1000, rdata=0x8877665544332211 -> one beat at 0x1000, wstrb=0x00, resp_data=0x8877665544332211 at T+3.
- LH at addr=0x1007, beat0 rdata=0xAA00000000000000, beat1 rdata=0x00000000000000BB:
  - Two beats, at 0x1000 and 0x1008.
  - resp_data=0xFFFFFFFFFFFFBBAA; split_count=1.
- SW at addr=0x2006, wdata=0x11223344:
  - Beat0 at 0x2000: wstrb=0xC0, wdata[63:48]=0x3344.
  - Beat1 at 0x2008: wstrb=0x03, wdata[15:0]=0x1122.
  - resp_data=0.
- LBU at addr=0x3003, rdata=0x00000000F0000000 -> resp_data=0xF0. Hold mem_req_ready=0 for 4 cycles -> mem_addr, mem_we and mem_wstrb stay stable while mem_req_valid=1.
- Store with funct3=100 -> resp_err=1 at T+1, no mem_req_valid ever; spurious mem_rvalid in IDLE has no effect.
- Assert rst_n=0 while in WAIT1 of a split load -> outputs take reset values immediately, and a following mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/lsu_access_sequencer_if.sv
// rtl/lsu_access_sequencer_if.sv - request, memory-beat and response bundle for the LSU access sequencer
interface lsu_access_sequencer_if #(
    parameter int N      = 64,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [N-1:0]      req_wdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [N/8-1:0]    mem_wstrb;
    logic [N-1:0]      mem_wdata;
    logic              mem_rvalid;
    logic [N-1:0]      mem_rdata;

    logic              resp_valid;
    logic [N-1:0]      resp_data;
    logic              resp_err;
    logic [CNT_W-1:0]  split_count;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output resp_valid, resp_data, resp_err, split_count
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  resp_valid, resp_data, resp_err, split_count
    );
endinterface

// File: rtl/lsu_access_sequencer.sv
// rtl/lsu_access_sequencer.sv - sequences RV64 loads/stores onto an aligned 64-bit port, splitting boundary-crossing accesses
module lsu_access_sequencer #(
    parameter int N      = 64,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lsu_access_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ0  = 3'd1;
    localparam logic [2:0] WAIT0 = 3'd2;
    localparam logic [2:0] REQ1  = 3'd3;
    localparam logic [2:0] WAIT1 = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    logic [2:0]         state;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [2:0]         r_off;
    logic               r_split;
    logic [ADDR_W-1:0]  r_base;
    logic [N/4-1:0]     r_strb;
    logic [2*N-1:0]     r_wdata;
    logic [N-1:0]       r_beat0;
    logic [N-1:0]       r_resp;
    logic [CNT_W-1:0]   r_split_count;

    logic [2:0]         req_off;
    logic [3:0]         req_size;
    logic [7:0]         req_mask;
    logic               req_split;
    logic               req_legal;
    logic               accept;
    logic [N/4-1:0]     req_strb;
    logic [2*N-1:0]     req_wdata_sh;

    always_comb begin
        req_off  = bus.req_addr[2:0];
        req_size = 4'd1 << bus.req_funct3[1:0];
        case (bus.req_funct3[1:0])
            2'd0:    req_mask = 8'h01;
            2'd1:    req_mask = 8'h03;
            2'd2:    req_mask = 8'h0f;
            default: req_mask = 8'hff;
        endcase
        req_split    = ({1'b0, req_off} + req_size) > 4'd8;
        req_legal    = bus.req_we ? !bus.req_funct3[2] : (bus.req_funct3 != 3'b111);
        accept       = bus.req_valid && (state == IDLE);
        req_strb     = {8'h00, req_mask} << req_off;
        req_wdata_sh = {{N{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
    end

    function automatic logic [N-1:0] extend(input logic [2:0] f3, input logic [N-1:0] d);
        case (f3)
            3'b000:  extend = {{(N-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(N-16){d[15]}}, d[15:0]};
            3'b010:  extend = {{(N-32){d[31]}}, d[31:0]};
            3'b100:  extend = {{(N-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(N-16){1'b0}}, d[15:0]};
            3'b110:  extend = {{(N-32){1'b0}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    // The final beat is always the live mem_rdata; beat 0 sits below it only for split accesses.
    logic [2*N-1:0] raw_pair;
    logic [2*N-1:0] merged;
    logic [N-1:0]   done_data;

    always_comb begin
        raw_pair  = (state == WAIT1) ? {bus.mem_rdata, r_beat0} : {{N{1'b0}}, bus.mem_rdata};
        merged    = raw_pair >> {r_off, 3'b000};
        done_data = r_we ? {N{1'b0}} : extend(r_funct3, merged[N-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_off         <= 3'd0;
            r_split       <= 1'b0;
            r_base        <= {ADDR_W{1'b0}};
            r_strb        <= {(N/4){1'b0}};
            r_wdata       <= {(2*N){1'b0}};
            r_beat0       <= {N{1'b0}};
            r_resp        <= {N{1'b0}};
            r_split_count <= {CNT_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_off    <= req_off;
                        r_split  <= req_split;
                        r_base   <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                        r_strb   <= req_strb;
                        r_wdata  <= req_wdata_sh;
                        r_resp   <= {N{1'b0}};
                        if (req_legal) begin
                            state <= REQ0;
                            if (req_split) r_split_count <= r_split_count + 1'b1;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                REQ0: if (bus.mem_req_ready) state <= WAIT0;
                WAIT0: begin
                    if (bus.mem_rvalid) begin
                        r_beat0 <= bus.mem_rdata;
                        if (r_split) begin
                            state <= REQ1;
                        end else begin
                            r_resp <= done_data;
                            state  <= RESP;
                        end
                    end
                end
                REQ1: if (bus.mem_req_ready) state <= WAIT1;
                WAIT1: begin
                    if (bus.mem_rvalid) begin
                        r_resp <= done_data;
                        state  <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic beat_valid;
    logic beat1;
    logic beat_write;

    assign beat_valid = (state == REQ0) || (state == REQ1);
    assign beat1      = (state == REQ1);
    assign beat_write = beat_valid && r_we;

    // Beat fields read as zero outside a request so a stale store never shows strobes.
    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_req_valid = beat_valid;
    assign bus.mem_addr      = !beat_valid ? {ADDR_W{1'b0}} :
                               beat1 ? (r_base + {{(ADDR_W-4){1'b0}}, 4'd8}) : r_base;
    assign bus.mem_we        = beat_write;
    assign bus.mem_wstrb     = !beat_write ? {(N/8){1'b0}} :
                               beat1 ? r_strb[N/4-1:N/8] : r_strb[N/8-1:0];
    assign bus.mem_wdata     = !beat_write ? {N{1'b0}} :
                               beat1 ? r_wdata[2*N-1:N] : r_wdata[N-1:0];
    assign bus.resp_valid    = (state == RESP) || (state == ERR);
    assign bus.resp_data     = (state == RESP) ? r_resp : {N{1'b0}};
    assign bus.resp_err      = (state == ERR);
    assign bus.split_count   = r_split_count;

endmodule
